// File: rtl/fpu_wait_ctrl_if.sv
// Handshake bundle between the execute stage (master) and fpu_wait_ctrl (slave).
// The master issues FP ops, presents the fpu result and sees stall/write-back.
interface fpu_wait_ctrl_if;
  logic        issue;
  logic [3:0]  fpu_control;
  logic [5:0]  rd_in;
  logic        flush;
  logic [31:0] fpu_result;
  logic        stall;
  logic        busy;
  logic        wb_valid;
  logic [5:0]  wb_rd;
  logic [31:0] wb_data;

  modport master (
    output issue, fpu_control, rd_in, flush, fpu_result,
    input  stall, busy, wb_valid, wb_rd, wb_data
  );

  modport slave (
    input  issue, fpu_control, rd_in, flush, fpu_result,
    output stall, busy, wb_valid, wb_rd, wb_data
  );
endinterface

// File: rtl/fpu_wait_ctrl.sv
// Execute-stage sequencer for the multi-cycle fpu units. Stalls the pipeline
// while a multi-cycle op is in flight and emits one write-back pulse per op.
// Optional feature: define FPU_RESULT_REG_EN to register the write-back port
// (extra HOLD state, fpu_result captured on the DONE edge).
module fpu_wait_ctrl #(
  parameter int unsigned LAT_ADD  = 2,
  parameter int unsigned LAT_SUB  = 2,
  parameter int unsigned LAT_MUL  = 2,
  parameter int unsigned LAT_DIV  = 4,
  parameter int unsigned LAT_SQRT = 4,
  parameter int unsigned CNT_W    = 4
) (
  input logic            clk,
  input logic            rstn,
  fpu_wait_ctrl_if.slave bus_io
);

  typedef enum logic [1:0] {StIdle, StWait, StDone, StHold} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       rd_q, rd_d;
  logic [CNT_W-1:0] lat;
`ifdef FPU_RESULT_REG_EN
  logic [31:0]      data_q, data_d;
`endif

  // Latency of the op currently presented; zero means single-cycle.
  function automatic logic [CNT_W-1:0] op_lat(input logic [3:0] op);
    case (op)
      4'b0000: op_lat = CNT_W'(LAT_ADD);
      4'b0001: op_lat = CNT_W'(LAT_SUB);
      4'b0010: op_lat = CNT_W'(LAT_MUL);
      4'b0011: op_lat = CNT_W'(LAT_DIV);
      4'b0110: op_lat = CNT_W'(LAT_SQRT);
      default: op_lat = '0;
    endcase
  endfunction

  assign lat = op_lat(bus_io.fpu_control);

  // State register with asynchronous clear; reset drops any pending write-back.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rd_q    <= '0;
`ifdef FPU_RESULT_REG_EN
      data_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
`ifdef FPU_RESULT_REG_EN
      data_q  <= data_d;
`endif
    end
  end

  // Next-state logic: flush beats everything, issue is only taken in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
`ifdef FPU_RESULT_REG_EN
    data_d  = data_q;
`endif
    if (bus_io.flush) begin
      // In HOLD the op is already committed; the registered pulse still goes out.
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus_io.issue) begin
            if (lat != '0) begin
              rd_d    = bus_io.rd_in;
              cnt_d   = lat - CNT_W'(1);
              state_d = (lat == CNT_W'(1)) ? StDone : StWait;
            end else begin
`ifdef FPU_RESULT_REG_EN
              // Single-cycle ops also pass through the result register.
              rd_d    = bus_io.rd_in;
              data_d  = bus_io.fpu_result;
              state_d = StHold;
`endif
            end
          end
        end
        StWait: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = StDone;
          end
        end
        StDone: begin
          cnt_d = '0;
`ifdef FPU_RESULT_REG_EN
          data_d  = bus_io.fpu_result;
          state_d = StHold;
`else
          state_d = StIdle;
`endif
        end
        StHold: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output decode; write-back fields are forced to zero whenever wb_valid is low.
  always_comb begin
    bus_io.stall    = 1'b0;
    bus_io.busy     = (state_q != StIdle);
    bus_io.wb_valid = 1'b0;
    bus_io.wb_rd    = '0;
    bus_io.wb_data  = '0;
    unique case (state_q)
      StIdle: begin
        if (bus_io.issue) begin
`ifdef FPU_RESULT_REG_EN
          bus_io.stall = 1'b1;
`else
          if (lat != '0) begin
            bus_io.stall = 1'b1;
          end else if (!bus_io.flush) begin
            bus_io.wb_valid = 1'b1;
            bus_io.wb_rd    = bus_io.rd_in;
            bus_io.wb_data  = bus_io.fpu_result;
          end
`endif
        end
      end
      StWait: begin
        bus_io.stall = 1'b1;
      end
      StDone: begin
`ifdef FPU_RESULT_REG_EN
        bus_io.stall = 1'b1;
`else
        if (!bus_io.flush) begin
          bus_io.wb_valid = 1'b1;
          bus_io.wb_rd    = rd_q;
          bus_io.wb_data  = bus_io.fpu_result;
        end
`endif
      end
      StHold: begin
`ifdef FPU_RESULT_REG_EN
        bus_io.wb_valid = 1'b1;
        bus_io.wb_rd    = rd_q;
        bus_io.wb_data  = data_q;
`endif
      end
      default: begin
        bus_io.stall = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fpu_wait_ctrl.sv
// Table-driven bench for fpu_wait_ctrl: one vector per clock cycle, inputs
// driven just after the rising edge, outputs compared on the falling edge.
module tb_fpu_wait_ctrl;

  localparam logic [31:0] Junk = 32'hDEADBEEF;

  typedef struct {
    logic        issue;
    logic [3:0]  op;
    logic [5:0]  rd;
    logic        flush;
    logic [31:0] res;
    logic        e_stall;
    logic        e_busy;
    logic        e_wbv;
    logic [5:0]  e_wbrd;
    logic [31:0] e_wbdata;
  } vec_t;

  logic clk;
  logic rstn;
  int   n_pass;
  int   n_total;
  vec_t vq[$];

  fpu_wait_ctrl_if bus ();

  fpu_wait_ctrl dut (
    .clk    (clk),
    .rstn   (rstn),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic v(input logic i, input logic [3:0] op, input logic [5:0] rd, input logic fl,
                   input logic [31:0] res, input logic st, input logic bz, input logic wv,
                   input logic [5:0] wrd, input logic [31:0] wd);
    vec_t x;
    x.issue = i;     x.op = op;         x.rd = rd;        x.flush = fl;   x.res = res;
    x.e_stall = st;  x.e_busy = bz;     x.e_wbv = wv;     x.e_wbrd = wrd; x.e_wbdata = wd;
    vq.push_back(x);
  endtask

  task automatic idle_inputs();
    bus.issue       = 1'b0;
    bus.fpu_control = 4'b0000;
    bus.rd_in       = 6'd0;
    bus.flush       = 1'b0;
    bus.fpu_result  = Junk;
  endtask

  // Apply the queued vectors, one per cycle, starting just after a rising edge.
  task automatic run_vecs(input string tag);
    foreach (vq[i]) begin
      bus.issue       = vq[i].issue;
      bus.fpu_control = vq[i].op;
      bus.rd_in       = vq[i].rd;
      bus.flush       = vq[i].flush;
      bus.fpu_result  = vq[i].res;
      @(negedge clk);
      check($sformatf("%s[%0d].stall", tag, i), 32'(bus.stall), 32'(vq[i].e_stall));
      check($sformatf("%s[%0d].busy", tag, i), 32'(bus.busy), 32'(vq[i].e_busy));
      check($sformatf("%s[%0d].wb_valid", tag, i), 32'(bus.wb_valid), 32'(vq[i].e_wbv));
      check($sformatf("%s[%0d].wb_rd", tag, i), 32'(bus.wb_rd), 32'(vq[i].e_wbrd));
      check($sformatf("%s[%0d].wb_data", tag, i), bus.wb_data, vq[i].e_wbdata);
      @(posedge clk);
      #1;
    end
    vq.delete();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rstn    = 1'b0;
    idle_inputs();
    #1;
    check("reset.stall", 32'(bus.stall), 32'd0);
    check("reset.busy", 32'(bus.busy), 32'd0);
    check("reset.wb_valid", 32'(bus.wb_valid), 32'd0);
    check("reset.wb_rd", 32'(bus.wb_rd), 32'd0);
    check("reset.wb_data", bus.wb_data, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Async reset in the middle of an fdiv wait.
    bus.issue       = 1'b1;
    bus.fpu_control = 4'b0011;
    bus.rd_in       = 6'd9;
    @(posedge clk);
    #1;
    bus.issue = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid.busy_before", 32'(bus.busy), 32'd1);
    check("rst_mid.stall_before", 32'(bus.stall), 32'd1);
    rstn = 1'b0;
    #1;
    check("rst_mid.stall", 32'(bus.stall), 32'd0);
    check("rst_mid.busy", 32'(bus.busy), 32'd0);
    check("rst_mid.wb_valid", 32'(bus.wb_valid), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("rst_after[%0d].wb_valid", k), 32'(bus.wb_valid), 32'd0);
      check($sformatf("rst_after[%0d].busy", k), 32'(bus.busy), 32'd0);
      @(posedge clk);
      #1;
    end

`ifndef FPU_RESULT_REG_EN
    // fadd 1.0 + 2.0 -> rd 5
    v(1'b1, 4'b0000, 6'd5, 1'b0, Junk,         1'b1, 1'b0, 1'b0, 6'd0, 32'h0);
    v(1'b0, 4'b0000, 6'd5, 1'b0, Junk,         1'b1, 1'b1, 1'b0, 6'd0, 32'h0);
    v(1'b0, 4'b0000, 6'd5, 1'b0, 32'h40400000, 1'b0, 1'b1, 1'b1, 6'd5, 32'h40400000);
    v(1'b0, 4'b0000, 6'd0, 1'b0, Junk,         1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
    // fsub -> rd 33
    v(1'b1, 4'b0001, 6'd33, 1'b0, Junk,        1'b1, 1'b0, 1'b0, 6'd0, 32'h0);
    v(1'b0, 4'b0001, 6'd33, 1'b0, Junk,        1'b1, 1'b1, 1'b0, 6'd0, 32'h0);
    v(1'b0, 4'b0001, 6'd33, 1'b0, 32'hBF800000, 1'b0, 1'b1, 1'b1, 6'd33, 32'hBF800000);
    // fdiv 1.0 / 4.0 -> rd 9
    v(1'b1, 4'b0011, 6'd9, 1'b0, Junk,         1'b1, 1'b0, 1'b0, 6'd0, 32'h0);
    v(1'b0, 4'b0011, 6'd9, 1'b0, Junk,         1'b1, 1'b1, 1'b0, 6'd0, 32'h0);
    v(1'b0, 4'b0011, 6'd9, 1'b0, Junk,         1'b1, 1'b1, 1'b0, 6'd0, 32'h0);
    v(1'b0, 4'b0011, 6'd9, 1'b0, Junk,         1'b1, 1'b1, 1'b0, 6'd0, 32'h0);
    v(1'b0, 4'b0011, 6'd9, 1'b0, 32'h3E800000, 1'b0, 1'b1, 1'b1, 6'd9, 32'h3E800000);
    v(1'b0, 4'b0000, 6'd0, 1'b0, Junk,         1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
    // Single-cycle ops: fneg, undefined code 1010, fneg killed by flush
    v(1'b1, 4'b0100, 6'd2, 1'b0, 32'hC0000000, 1'b0, 1'b0, 1'b1, 6'd2, 32'hC0000000);
    v(1'b1, 4'b1010, 6'd7, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 6'd7, 32'h0);
    v(1'b1, 4'b0100, 6'd6, 1'b1, Junk,         1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
    v(1'b0, 4'b0100, 6'd6, 1'b0, Junk,         1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
    // fsqrt flushed at T+2, nothing written back through T+10
    v(1'b1, 4'b0110, 6'd3, 1'b0, Junk,         1'b1, 1'b0, 1'b0, 6'd0, 32'h0);
    v(1'b0, 4'b0110, 6'd3, 1'b0, Junk,         1'b1, 1'b1, 1'b0, 6'd0, 32'h0);
    v(1'b0, 4'b0110, 6'd3, 1'b1, Junk,         1'b1, 1'b1, 1'b0, 6'd0, 32'h0);
    for (int k = 0; k < 8; k++) begin
      v(1'b0, 4'b0110, 6'd3, 1'b0, Junk,       1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
    end
    // fmul with flush landing on DONE: flush wins
    v(1'b1, 4'b0010, 6'd4, 1'b0, Junk,         1'b1, 1'b0, 1'b0, 6'd0, 32'h0);
    v(1'b0, 4'b0010, 6'd4, 1'b0, Junk,         1'b1, 1'b1, 1'b0, 6'd0, 32'h0);
    v(1'b0, 4'b0010, 6'd4, 1'b1, Junk,         1'b0, 1'b1, 1'b0, 6'd0, 32'h0);
    v(1'b0, 4'b0000, 6'd0, 1'b0, Junk,         1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
    // Back-to-back fmul: second presented in DONE is ignored, re-presented next cycle
    v(1'b1, 4'b0010, 6'd11, 1'b0, Junk,        1'b1, 1'b0, 1'b0, 6'd0, 32'h0);
    v(1'b0, 4'b0010, 6'd11, 1'b0, Junk,        1'b1, 1'b1, 1'b0, 6'd0, 32'h0);
    v(1'b1, 4'b0010, 6'd12, 1'b0, 32'h40C00000, 1'b0, 1'b1, 1'b1, 6'd11, 32'h40C00000);
    v(1'b1, 4'b0010, 6'd12, 1'b0, Junk,        1'b1, 1'b0, 1'b0, 6'd0, 32'h0);
    v(1'b0, 4'b0010, 6'd12, 1'b0, Junk,        1'b1, 1'b1, 1'b0, 6'd0, 32'h0);
    v(1'b0, 4'b0010, 6'd12, 1'b0, 32'h41100000, 1'b0, 1'b1, 1'b1, 6'd12, 32'h41100000);
    v(1'b0, 4'b0000, 6'd0, 1'b0, Junk,         1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
    run_vecs("comb");
`else
    // fneg through the result register: stall one cycle, pulse at T+1
    v(1'b1, 4'b0100, 6'd2, 1'b0, 32'hC0000000, 1'b1, 1'b0, 1'b0, 6'd0, 32'h0);
    v(1'b0, 4'b0100, 6'd2, 1'b0, Junk,         1'b0, 1'b1, 1'b1, 6'd2, 32'hC0000000);
    v(1'b0, 4'b0000, 6'd0, 1'b0, Junk,         1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
    // fadd with flush during HOLD: still written back
    v(1'b1, 4'b0000, 6'd5, 1'b0, Junk,         1'b1, 1'b0, 1'b0, 6'd0, 32'h0);
    v(1'b0, 4'b0000, 6'd5, 1'b0, Junk,         1'b1, 1'b1, 1'b0, 6'd0, 32'h0);
    v(1'b0, 4'b0000, 6'd5, 1'b0, 32'h40400000, 1'b1, 1'b1, 1'b0, 6'd0, 32'h0);
    v(1'b0, 4'b0000, 6'd5, 1'b1, Junk,         1'b0, 1'b1, 1'b1, 6'd5, 32'h40400000);
    v(1'b0, 4'b0000, 6'd0, 1'b0, Junk,         1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
    // Back-to-back fmul: pulses four cycles apart
    v(1'b1, 4'b0010, 6'd11, 1'b0, Junk,        1'b1, 1'b0, 1'b0, 6'd0, 32'h0);
    v(1'b0, 4'b0010, 6'd11, 1'b0, Junk,        1'b1, 1'b1, 1'b0, 6'd0, 32'h0);
    v(1'b0, 4'b0010, 6'd11, 1'b0, 32'h40C00000, 1'b1, 1'b1, 1'b0, 6'd0, 32'h0);
    v(1'b1, 4'b0010, 6'd12, 1'b0, Junk,        1'b0, 1'b1, 1'b1, 6'd11, 32'h40C00000);
    v(1'b1, 4'b0010, 6'd12, 1'b0, Junk,        1'b1, 1'b0, 1'b0, 6'd0, 32'h0);
    v(1'b0, 4'b0010, 6'd12, 1'b0, Junk,        1'b1, 1'b1, 1'b0, 6'd0, 32'h0);
    v(1'b0, 4'b0010, 6'd12, 1'b0, 32'h41100000, 1'b1, 1'b1, 1'b0, 6'd0, 32'h0);
    v(1'b0, 4'b0010, 6'd12, 1'b0, Junk,        1'b0, 1'b1, 1'b1, 6'd12, 32'h41100000);
    v(1'b0, 4'b0000, 6'd0, 1'b0, Junk,         1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
    run_vecs("reg");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
